// File: rtl/data_mem_responder_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave).
//   req_valid/req_ready : request handshake; req_we/req_addr/req_wdata/req_size qualify it
//   rsp_valid/rsp_ready : response handshake; rsp_rdata/rsp_err qualify it
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder. Accepts one load/store at a time, waits
// WAIT_CYCLES, performs a byte/half/word little-endian access and returns data
// and status on a response held until taken.
//   clk : clock, rising edge
//   rst : synchronous active-high reset (memory contents are kept)
//   bus : slave side of data_mem_responder_if
// Size codes: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_size;
  logic        rsp_valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          access;
  logic          acc_err;
  logic [AW-1:0] widx;
  logic [31:0]   rd_word;
  logic [31:0]   shifted;
  logic [15:0]   half;
  logic [31:0]   load_data;
  logic [31:0]   wr_word;
  logic [3:0]    be;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign access  = (state == WAIT) && (cnt == 4'(WAIT_CYCLES));
  assign widx    = lat_addr[AW+1:2];
  assign rd_word = mem[widx];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = WAIT;
      WAIT:    if (access)        state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Access decode on the latched request: error, load extraction, store lanes.
  always_comb begin
    acc_err   = 1'b0;
    load_data = '0;
    wr_word   = '0;
    be        = '0;
    shifted   = rd_word >> {lat_addr[1:0], 3'b000};
    half      = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (lat_size)
      SZ_B: begin
        load_data = {{24{shifted[7]}}, shifted[7:0]};
        be        = 4'b0001 << lat_addr[1:0];
        wr_word   = {4{lat_wdata[7:0]}};
      end
      SZ_H: begin
        acc_err   = lat_addr[0];
        load_data = {{16{half[15]}}, half};
        be        = lat_addr[1] ? 4'b1100 : 4'b0011;
        wr_word   = {2{lat_wdata[15:0]}};
      end
      SZ_W: begin
        acc_err   = (lat_addr[1:0] != 2'b00);
        load_data = rd_word;
        be        = 4'b1111;
        wr_word   = lat_wdata;
      end
      SZ_BU: begin
        acc_err   = lat_we;
        load_data = {24'h0, shifted[7:0]};
      end
      SZ_HU: begin
        acc_err   = lat_we | lat_addr[0];
        load_data = {16'h0, half};
      end
      default: acc_err = 1'b1;
    endcase
    if ({1'b0, lat_addr} >= BYTE_LIMIT) acc_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      lat_size    <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.req_valid) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_size  <= bus.req_size;
          end
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (access) begin
            rsp_valid_q <= 1'b1;
            rdata_q     <= (acc_err || lat_we) ? '0 : load_data;
            err_q       <= acc_err;
          end
        end
        RESP: if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Memory is deliberately outside the reset; rst only suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && access && !acc_err && lat_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be[k]) mem[widx][8*k +: 8] <= wr_word[8*k +: 8];
      end
    end
  end

endmodule
